// File: rtl/fc_result_writer.sv
// Result writer for the 4-lane FC mover: captures lane results, applies ReLU,
// shift requantization and int8 saturation, and writes packed words to bram2.
module fc_result_writer #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned AWIDTH    = 12,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [AWIDTH-1:0] i_base_addr,
    input  logic [AWIDTH-1:0] i_num_grp,
    input  logic [4:0]        i_shift,
    input  logic              i_relu_en,
    input  logic              i_result_valid,
    input  logic [DWIDTH-1:0] i_result_0,
    input  logic [DWIDTH-1:0] i_result_1,
    input  logic [DWIDTH-1:0] i_result_2,
    input  logic [DWIDTH-1:0] i_result_3,
    output logic              o_idle,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overrun,
    output logic [AWIDTH-1:0] o_grp_cnt,
    output logic [AWIDTH-1:0] addr_b2,
    output logic              ce_b2,
    output logic              we_b2,
    output logic [DWIDTH-1:0] d_b2
);

    localparam logic signed [DWIDTH-1:0] QMAX = DWIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DWIDTH-1:0] QMIN = ~QMAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_QUANT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [AWIDTH-1:0] base_addr;
    logic [AWIDTH-1:0] num_grp;
    logic [4:0]        shift;
    logic              relu_en;
    logic [AWIDTH-1:0] grp_cnt;
    logic [DWIDTH-1:0] res_0, res_1, res_2, res_3;

    logic              start_acc;
    logic              capture;
    logic              overrun_set;
    logic [DWIDTH-1:0] q_word;

    // ReLU, arithmetic shift (floor) and signed saturation of one lane
    function automatic logic [OUT_WIDTH-1:0] quant(input logic [DWIDTH-1:0] r,
                                                   input logic [4:0] sh,
                                                   input logic relu);
        logic signed [DWIDTH-1:0] v;
        logic signed [DWIDTH-1:0] s;
        v = (relu && r[DWIDTH-1]) ? '0 : $signed(r);
        s = v >>> sh;
        if (s > QMAX)
            return QMAX[OUT_WIDTH-1:0];
        else if (s < QMIN)
            return QMIN[OUT_WIDTH-1:0];
        else
            return s[OUT_WIDTH-1:0];
    endfunction

    always_comb begin
        next_state  = state;
        start_acc   = 1'b0;
        capture     = 1'b0;
        overrun_set = 1'b0;
        q_word      = {quant(res_0, shift, relu_en), quant(res_1, shift, relu_en),
                       quant(res_2, shift, relu_en), quant(res_3, shift, relu_en)};
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_acc  = 1'b1;
                    next_state = (i_num_grp == '0) ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_result_valid) begin
                    capture    = 1'b1;
                    next_state = S_QUANT;
                end
            end
            S_QUANT: begin
                overrun_set = i_result_valid;
                next_state  = S_WRITE;
            end
            S_WRITE: begin
                overrun_set = i_result_valid;
                next_state  = (grp_cnt == num_grp - AWIDTH'(1)) ? S_DONE : S_WAIT;
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Status and BRAM outputs are registered from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            o_idle    <= 1'b1;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
            base_addr <= '0;
            num_grp   <= '0;
            shift     <= '0;
            relu_en   <= 1'b0;
            grp_cnt   <= '0;
            res_0     <= '0;
            res_1     <= '0;
            res_2     <= '0;
            res_3     <= '0;
            addr_b2   <= '0;
            ce_b2     <= 1'b0;
            we_b2     <= 1'b0;
            d_b2      <= '0;
        end else begin
            state  <= next_state;
            o_idle <= (next_state == S_IDLE);
            o_busy <= (next_state != S_IDLE);
            o_done <= (next_state == S_DONE);

            if (start_acc) begin
                base_addr <= i_base_addr;
                num_grp   <= i_num_grp;
                shift     <= i_shift;
                relu_en   <= i_relu_en;
                grp_cnt   <= '0;
                o_overrun <= 1'b0;
            end else begin
                if (state == S_WRITE)
                    grp_cnt <= grp_cnt + AWIDTH'(1);
                if (overrun_set)
                    o_overrun <= 1'b1;
            end

            if (capture) begin
                res_0 <= i_result_0;
                res_1 <= i_result_1;
                res_2 <= i_result_2;
                res_3 <= i_result_3;
            end

            if (next_state == S_WRITE) begin
                addr_b2 <= base_addr + grp_cnt;
                ce_b2   <= 1'b1;
                we_b2   <= 1'b1;
                d_b2    <= q_word;
            end else begin
                addr_b2 <= '0;
                ce_b2   <= 1'b0;
                we_b2   <= 1'b0;
                d_b2    <= '0;
            end
        end
    end

    assign o_grp_cnt = grp_cnt;

endmodule
